// File: rtl/cache_mem_arbiter.sv
// Shares one AXI-bridge request port between the I-cache and the D-cache, one
// transaction at a time; data wins ties until inst has watched MAX_DATA_STREAK data grants.
module cache_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } state_t;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);

  state_t     state_r;
  state_t     state_s;
  logic [2:0] streak_r;
  logic [2:0] streak_s;

  // state and streak registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      streak_r <= 3'd0;
    end else begin
      state_r  <= state_s;
      streak_r <= streak_s;
    end
  end

  // arbitration and transaction sequencing; grants are only made from IDLE
  always_comb begin
    state_s  = state_r;
    streak_s = streak_r;
    case (state_r)
      IDLE: begin
        if (inst_req && (!data_req || streak_r == STREAK_MAX)) begin
          state_s  = I_ADDR;
          streak_s = 3'd0;
        end else if (data_req) begin
          state_s = D_ADDR;
          if (!inst_req) begin
            streak_s = 3'd0;
          end else if (streak_r < STREAK_MAX) begin
            streak_s = streak_r + 3'd1;
          end else begin
            streak_s = streak_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      I_ADDR: begin
        if (inst_req && mem_addr_ok) begin
          state_s = I_DATA;
        end else begin
          state_s = I_ADDR;
        end
      end
      I_DATA: begin
        if (mem_data_ok) begin
          state_s = IDLE;
        end else begin
          state_s = I_DATA;
        end
      end
      D_ADDR: begin
        if (data_req && mem_addr_ok) begin
          state_s = D_DATA;
        end else begin
          state_s = D_ADDR;
        end
      end
      D_DATA: begin
        if (mem_data_ok) begin
          state_s = IDLE;
        end else begin
          state_s = D_DATA;
        end
      end
      default: begin
        state_s  = IDLE;
        streak_s = 3'd0;
      end
    endcase
  end

  // bus steering: handshakes pass through to the owner only in its own phase
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'b00;
    mem_addr     = 32'h0000_0000;
    mem_wdata    = 32'h0000_0000;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_r)
      I_ADDR: begin
        mem_req      = inst_req;
        mem_size     = 2'b10;
        mem_addr     = inst_addr;
        inst_addr_ok = inst_req & mem_addr_ok;
      end
      I_DATA: begin
        inst_data_ok = mem_data_ok;
      end
      D_ADDR: begin
        mem_req      = data_req;
        mem_wr       = data_wr;
        mem_size     = data_size;
        mem_addr     = data_addr;
        mem_wdata    = data_wdata;
        data_addr_ok = data_req & mem_addr_ok;
      end
      D_DATA: begin
        data_data_ok = mem_data_ok;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: queued cache commands, a randomized bridge
// responder, a transaction-level reference model and a decoupled output monitor.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cache_mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic wr; logic [1:0] size; logic [31:0] wdata; } cmd_t;
  typedef struct { bit src; logic [31:0] addr; logic wr; logic [1:0] size; logic [31:0] wdata; } aexp_t;
  typedef struct { bit src; logic [31:0] rdata; } dexp_t;

  cmd_t  i_cmd_q[$], d_cmd_q[$];
  aexp_t addr_q[$];
  dexp_t data_q[$];
  bit    grant_log[$];  // 1 = data cache, 0 = inst cache

  int total = 0, bad = 0;
  int issue_pct = 100, addr_lat = 1, data_lat = 2;
  bit rand_dlat = 1'b0, noise = 1'b0, hold_aok = 1'b0, fix_rdata = 1'b0;
  logic [31:0] rdata_val = 32'h0;
  int i_st = 0, d_st = 0;       // 0 idle, 1 requesting, 2 awaiting data
  int m_ph = 0;                 // model phase: 0 idle, 1 address, 2 data
  bit m_own = 1'b0;
  logic exp_req = 1'b0;
  bit exp_idle = 1'b1;
  int iaok_cnt = 0, dok_cnt = 0;
  logic [31:0] last_i_rdata = 32'h0, last_d_addr = 32'h0, last_d_wdata = 32'h0;
  logic        last_d_wr = 1'b0;
  logic [1:0]  last_d_size = 2'b00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.addr  = $urandom;
    c.wr    = 1'($urandom_range(0, 1));
    c.size  = 2'($urandom_range(0, 2));
    c.wdata = $urandom;
    return c;
  endfunction

  // two caches: each issues one queued command at a time, holds it until accepted
  initial begin : caches
    cmd_t c;
    logic iaok, idok, daok, ddok;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = 32'h0; data_wdata = 32'h0;
    forever begin
      @(negedge clk);
      iaok = inst_addr_ok; idok = inst_data_ok; daok = data_addr_ok; ddok = data_data_ok;
      @(posedge clk); #1;
      if (!resetn) begin
        i_st = 0; d_st = 0; inst_req = 1'b0; data_req = 1'b0;
      end else begin
        if (i_st == 1 && iaok) begin i_st = 2; inst_req = 1'b0; end
        else if (i_st == 2 && idok) i_st = 0;
        if (d_st == 1 && daok) begin d_st = 2; data_req = 1'b0; end
        else if (d_st == 2 && ddok) d_st = 0;
        if (i_st == 0 && i_cmd_q.size() > 0 && $urandom_range(99) < issue_pct) begin
          c = i_cmd_q.pop_front();
          inst_req = 1'b1; inst_addr = c.addr; i_st = 1;
        end
        if (d_st == 0 && d_cmd_q.size() > 0 && $urandom_range(99) < issue_pct) begin
          c = d_cmd_q.pop_front();
          data_req = 1'b1; data_addr = c.addr; data_wr = c.wr;
          data_size = c.size; data_wdata = c.wdata; d_st = 1;
        end
      end
    end
  end

  // bridge responder, independent of the arbiter reset; may inject stray handshakes
  initial begin : bridge
    int req_cnt, wcnt;
    bit waiting;
    logic s_req, s_aok;
    req_cnt = 0; wcnt = 0; waiting = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      s_req = mem_req; s_aok = mem_addr_ok;
      @(posedge clk); #1;
      req_cnt = s_req ? req_cnt + 1 : 0;
      mem_data_ok = 1'b0;
      if (!waiting && s_req && s_aok) begin
        waiting = 1'b1;
        wcnt = rand_dlat ? int'($urandom_range(1, 5)) : data_lat;
      end
      if (waiting) begin
        wcnt--;
        if (wcnt == 0) begin mem_data_ok = 1'b1; waiting = 1'b0; end
      end else begin
        mem_data_ok = noise && ($urandom_range(3) == 0);
      end
      mem_addr_ok = hold_aok || (s_req && !s_aok && req_cnt >= addr_lat)
                    || (noise && ($urandom_range(3) == 0));
      mem_rdata = fix_rdata ? rdata_val : $urandom;
    end
  end

  // reference model: one transaction at a time, tie rule by count of data grants inst watched
  initial begin : model
    int watched;
    bit give_inst, own_req;
    watched = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_ph = 0; watched = 0; exp_req = 1'b0; exp_idle = 1'b1;
      end else begin
        case (m_ph)
          0: begin
            exp_req = 1'b0; exp_idle = 1'b1;
            if (inst_req || data_req) begin
              give_inst = inst_req && (!data_req || watched >= MAXS);
              m_own = !give_inst;
              watched = (give_inst || !inst_req) ? 0 : watched + 1;
              m_ph = 1;
            end
          end
          1: begin
            exp_idle = 1'b0;
            own_req = m_own ? data_req : inst_req;
            exp_req = own_req;
            if (own_req && mem_addr_ok) begin
              if (m_own) addr_q.push_back('{1'b1, data_addr, data_wr, data_size, data_wdata});
              else       addr_q.push_back('{1'b0, inst_addr, 1'b0, 2'b10, 32'h0});
              m_ph = 2;
            end
          end
          default: begin
            exp_req = 1'b0; exp_idle = 1'b0;
            if (mem_data_ok) begin
              data_q.push_back('{m_own, mem_rdata});
              m_ph = 0;
            end
          end
        endcase
      end
    end
  end

  // monitor: compares every DUT handshake against the scoreboard queues
  initial begin : monitor
    aexp_t a;
    dexp_t d;
    forever begin
      @(negedge clk); #1;
      chk("mem_req", mem_req, exp_req);
      chk("ok_exclusive", {inst_addr_ok & data_addr_ok, inst_data_ok & data_data_ok}, 2'b00);
      if (exp_idle)
        chk("idle_bus", {mem_addr, mem_wdata, mem_wr, mem_size}, 67'h0);
      if (inst_addr_ok || data_addr_ok) begin
        grant_log.push_back(data_addr_ok);
        if (inst_addr_ok) iaok_cnt++;
        if (data_addr_ok) begin
          last_d_addr = mem_addr; last_d_wr = mem_wr; last_d_size = mem_size; last_d_wdata = mem_wdata;
        end
        chk("addr_ok_expected", addr_q.size() > 0, 1'b1);
        if (addr_q.size() > 0) begin
          a = addr_q.pop_front();
          chk("addr_phase", {data_addr_ok, mem_addr, mem_wr, mem_size, mem_wdata},
              {a.src, a.addr, a.wr, a.size, a.wdata});
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (inst_data_ok) last_i_rdata = inst_rdata;
        if (data_data_ok) dok_cnt++;
        chk("data_ok_expected", data_q.size() > 0, 1'b1);
        if (data_q.size() > 0) begin
          d = data_q.pop_front();
          chk("data_phase", {data_data_ok, data_data_ok ? data_rdata : inst_rdata}, {d.src, d.rdata});
          chk("rdata_other", data_data_ok ? inst_rdata : data_rdata, mem_rdata);
        end
      end
    end
  end

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(i_cmd_q.size() == 0 && d_cmd_q.size() == 0 && i_st == 0 && d_st == 0
                 && m_ph == 0) && n < limit);
    chk(name, n < limit, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, n;
    logic [9:0] got;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_outputs", {mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_addr}, 37'h0);
    @(posedge clk); #3; resetn = 1'b1;

    // single instruction read with fixed bridge timing
    fix_rdata = 1'b1; rdata_val = 32'h3C08_0001; addr_lat = 1; data_lat = 2;
    base = dok_cnt;
    i_cmd_q.push_back('{32'hBFC0_0000, 1'b0, 2'b10, 32'h0});
    wait_idle(100, "inst_read_done");
    chk("inst_rdata_value", last_i_rdata, 32'h3C08_0001);
    chk("inst_read_no_dok", dok_cnt - base, 0);
    fix_rdata = 1'b0;

    // byte write from the data cache
    base = dok_cnt;
    d_cmd_q.push_back('{32'h8000_1003, 1'b1, 2'b00, 32'h0000_00AA});
    wait_idle(100, "dwrite_done");
    chk("dwrite_fields", {last_d_addr, last_d_wr, last_d_size, last_d_wdata},
        {32'h8000_1003, 1'b1, 2'b00, 32'h0000_00AA});
    chk("dwrite_dok", dok_cnt - base, 1);

    // simultaneous requests with empty streak: data first
    base = grant_log.size();
    d_cmd_q.push_back(rnd_cmd());
    i_cmd_q.push_back(rnd_cmd());
    wait_idle(100, "simul_done");
    chk("simul_count", grant_log.size() - base, 2);
    chk("simul_order", {grant_log[base], grant_log[base+1]}, 2'b10);

    // both held continuously: streak bound gives inst every fifth grant
    base = grant_log.size();
    for (int k = 0; k < 8; k++) d_cmd_q.push_back(rnd_cmd());
    for (int k = 0; k < 2; k++) i_cmd_q.push_back(rnd_cmd());
    wait_idle(400, "streak_done");
    for (int k = 0; k < 10; k++) got[9-k] = grant_log[base+k];
    chk("streak_order", got, 10'b1111011110);

    // reset during the data phase; late bridge response must be ignored
    data_lat = 6; base = dok_cnt;
    d_cmd_q.push_back('{32'h8000_0040, 1'b0, 2'b10, 32'h0});
    n = 0;
    while (m_ph != 2 && n < 50) begin @(negedge clk); #2; n++; end
    chk("reach_d_data", m_ph, 2);
    @(posedge clk); #3; resetn = 1'b0;
    #1 chk("async_reset", {mem_req, data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok}, 5'b0);
    repeat (3) @(posedge clk);
    #3; resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_dok_after_reset", dok_cnt - base, 0);
    wait_idle(50, "reset_idle");

    // bridge holds addr_ok high and stalls data
    hold_aok = 1'b1; data_lat = 10; base = iaok_cnt;
    i_cmd_q.push_back(rnd_cmd());
    wait_idle(100, "stall_done");
    chk("single_iaok", iaok_cnt - base, 1);
    hold_aok = 1'b0;
    repeat (3) @(negedge clk);

    // randomized traffic with stray bridge handshakes
    noise = 1'b1; rand_dlat = 1'b1;
    for (int b = 0; b < 4; b++) begin
      addr_lat  = $urandom_range(1, 3);
      issue_pct = $urandom_range(30, 100);
      for (int k = 0; k < 15; k++) begin
        i_cmd_q.push_back(rnd_cmd());
        d_cmd_q.push_back(rnd_cmd());
      end
      wait_idle(3000, "random_batch_done");
    end
    noise = 1'b0;
    repeat (8) @(negedge clk);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("data_q_drained", data_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
